mem_bus_target: RTL and testbench
=================================

# mem_bus_target

Memory-side endpoint of the CPU's byte-serial handshake bus. It synchronises the CPU's request/strobe lines, reassembles the three-phase transfer (address low, address high, data) and issues one parallel read or write on a variable-latency memory port. For reads it drives the returned byte back onto the shared 8-bit bus. It sits directly downstream of the CPU bus master, either in the board FPGA or in the co-simulation harness.

## Interface
Parameters:
- SYNC_STAGES, default 2: flop stages on req, rd and wr; legal values are 2 or 3.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  1  CPU handshake request (uo_out[0]); asynchronous to clk.
- wr  in  1  CPU write strobe (uo_out[1]); asynchronous.
- rd  in  1  CPU read strobe (uo_out[2]); asynchronous.
- bus_in  in  8  shared bus, CPU-driven value.
- bus_out  out  8  shared bus, target-driven value.
- bus_oe  out  1  target drives the bus when 1.
- ack  out  1  handshake acknowledge to the CPU (ui_in[0]).
- mem_addr  out  16  parallel address; held for the whole access.
- mem_wdata  out  8  write data.
- mem_we  out  1  write request; level, held until mem_ready.
- mem_re  out  1  read request; level, held until mem_ready.
- mem_rdata  in  8  read data; valid when mem_ready=1 during a read.
- mem_ready  in  1  access complete, single-cycle pulse.
- err  out  1  sticky protocol error.

## Operation
- req, rd and wr pass through SYNC_STAGES flops. All logic below uses only the synchronised versions (s_req, s_rd, s_wr).
- The bus uses a four-phase handshake. The CPU raises req with its byte on the bus. The target raises ack. The CPU drops req. The target drops ack. The CPU never raises req again while ack=1.
- FSM states and transitions:
  - A_LO_WAIT: on s_req=1, latch bus_in into addr[7:0] and go to A_LO_ACK.
  - A_LO_ACK: ack=1. On s_req=0, go to A_HI_WAIT.
  - A_HI_WAIT: on s_req=1, latch bus_in into addr[15:8] and go to A_HI_ACK.
  - A_HI_ACK: ack=1. On s_req=0, go to D_WAIT.
  - D_WAIT: on s_req=1 with s_wr=1, latch bus_in into mem_wdata and go to D_WRITE. On s_req=1 with s_rd=1, go to D_READ.
  - D_WRITE: mem_we=1. On mem_ready, go to D_ACK.
  - D_READ: mem_re=1. On mem_ready, latch mem_rdata into bus_out, set bus_oe=1 and go to D_ACK.
  - D_ACK: ack=1, bus_oe held if the access was a read. On s_req=0, clear ack and bus_oe in the same cycle and go to A_LO_WAIT.
- mem_addr always equals {addr[15:8], addr[7:0]}.
- Abort: in any state other than A_LO_WAIT, if s_rd=0 and s_wr=0 while s_req=0, the target returns to A_LO_WAIT with ack=0 and bus_oe=0. This covers a CPU reset mid-transfer. During D_WRITE or D_READ, mem_we/mem_re stay asserted until mem_ready, then the abort takes effect.
- Error: s_req rising with s_rd=1 and s_wr=1 sets err. The target treats the transfer as a write. err is cleared only by rst_n.
- s_req rising in D_WAIT with s_rd=0 and s_wr=0 sets err and takes the abort path.
- No byte enables, no bursts, no address auto-increment.

## Timing
- Reset values: ack=0, bus_oe=0, bus_out=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, err=0, state A_LO_WAIT. rst_n deassertion mid-transfer discards all latched bytes.
- Edge to response: an edge on req reaches s_req after SYNC_STAGES cycles. ack or state responds one cycle later, so the default is 3 clk.
- Write latency: mem_we rises 1 cycle after s_req is seen in D_WAIT. ack rises the cycle after mem_ready.
- Read latency: mem_re rises 1 cycle after s_req is seen in D_WAIT. bus_out and bus_oe become valid the cycle after mem_ready, in the same cycle ack rises. They stay stable until ack falls.
- mem_ready arriving in the same cycle mem_we/mem_re first rises is legal. The access then completes in 1 cycle.
- mem_ready outside D_WRITE or D_READ is ignored.
- bus_oe is never 1 outside D_ACK.

## Test plan
- Write: CPU sends addr 0x34, 0x12, then data 0xA5 with wr=1, mem_ready after 4 cycles -> one mem_we pulse train with mem_addr=0x1234 and mem_wdata=0xA5. ack cycles exactly 3 times. err=0.
- Read: addr 0xBEEF, rd=1, memory returns 0x5C with mem_ready after 0 cycles -> mem_re asserted for 1 cycle. bus_oe=1 and bus_out=0x5C while ack=1. bus_oe falls in the same cycle ack falls.
- Back-to-back: read 0x0000 then write 0xFFFF/0x01 with no idle cycles -> two correct accesses. bus_oe=0 throughout the second transfer's address phases.
- Abort: after the address-high ack, drop rd, wr and req -> target returns to A_LO_WAIT with ack=0, and no mem_re/mem_we is issued. A following full read of 0x0102 completes correctly.
- Error: req with rd=1 and wr=1 in the data phase -> err=1, the write is performed, and err stays 1 until rst_n.
- Reset mid-read: rst_n asserted during D_READ -> ack, bus_oe, mem_re and err all 0 asynchronously. A new transfer after release uses fresh address bytes.

Source files
------------

// File: rtl/mem_bus_target.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_target
//  Purpose  : Memory-side endpoint of the CPU byte-serial handshake bus.
//             Collects address-low, address-high and data bytes, then issues a
//             single parallel read or write on a variable-latency memory port.
//  Revision : 1.0  initial release
// ============================================================================
module mem_bus_target #(
    parameter int SYNC_STAGES = 2    // legal values: 2 or 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic        rd_i,
    input  logic [7:0]  bus_i,
    output logic [7:0]  bus_o,
    output logic        bus_oe_o,
    output logic        ack_o,
    output logic [15:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    output logic        mem_we_o,
    output logic        mem_re_o,
    input  logic [7:0]  mem_rdata_i,
    input  logic        mem_ready_i,
    output logic        err_o
);

    typedef enum logic [2:0] {
        A_LO_WAIT = 3'd0,
        A_LO_ACK  = 3'd1,
        A_HI_WAIT = 3'd2,
        A_HI_ACK  = 3'd3,
        D_WAIT    = 3'd4,
        D_WRITE   = 3'd5,
        D_READ    = 3'd6,
        D_ACK     = 3'd7
    } state_t;

    logic [SYNC_STAGES-1:0] req_sync_q;
    logic [SYNC_STAGES-1:0] rd_sync_q;
    logic [SYNC_STAGES-1:0] wr_sync_q;

    state_t      state_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  bus_out_q;
    logic        bus_oe_q;
    logic        ack_q;
    logic        we_q;
    logic        re_q;
    logic        err_q;
    logic        req_prev_q;

    logic s_req;
    logic s_rd;
    logic s_wr;
    logic w_req_rise;
    logic w_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_sync_q <= '0;
            rd_sync_q  <= '0;
            wr_sync_q  <= '0;
        end else begin
            req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_i};
            rd_sync_q  <= {rd_sync_q[SYNC_STAGES-2:0],  rd_i};
            wr_sync_q  <= {wr_sync_q[SYNC_STAGES-2:0],  wr_i};
        end
    end

    assign s_req      = req_sync_q[SYNC_STAGES-1];
    assign s_rd       = rd_sync_q[SYNC_STAGES-1];
    assign s_wr       = wr_sync_q[SYNC_STAGES-1];
    assign w_req_rise = s_req & ~req_prev_q;
    // All strobes low with req low means the CPU has abandoned the transfer.
    assign w_abort    = ~s_req & ~s_rd & ~s_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= A_LO_WAIT;
            addr_q     <= '0;
            wdata_q    <= '0;
            bus_out_q  <= '0;
            bus_oe_q   <= 1'b0;
            ack_q      <= 1'b0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            err_q      <= 1'b0;
            req_prev_q <= 1'b0;
        end else begin
            req_prev_q <= s_req;
            if (w_req_rise && s_rd && s_wr) begin
                err_q <= 1'b1;
            end
            case (state_q)
                A_LO_WAIT: begin
                    if (s_req) begin
                        addr_q[7:0] <= bus_i;
                        ack_q       <= 1'b1;
                        state_q     <= A_LO_ACK;
                    end
                end
                A_LO_ACK: begin
                    if (!s_req) begin
                        ack_q   <= 1'b0;
                        state_q <= w_abort ? A_LO_WAIT : A_HI_WAIT;
                    end
                end
                A_HI_WAIT: begin
                    if (w_abort) begin
                        state_q <= A_LO_WAIT;
                    end else if (s_req) begin
                        addr_q[15:8] <= bus_i;
                        ack_q        <= 1'b1;
                        state_q      <= A_HI_ACK;
                    end
                end
                A_HI_ACK: begin
                    if (!s_req) begin
                        ack_q   <= 1'b0;
                        state_q <= w_abort ? A_LO_WAIT : D_WAIT;
                    end
                end
                D_WAIT: begin
                    if (w_abort) begin
                        state_q <= A_LO_WAIT;
                    end else if (s_req) begin
                        // Write wins when both strobes are high.
                        if (s_wr) begin
                            wdata_q <= bus_i;
                            we_q    <= 1'b1;
                            state_q <= D_WRITE;
                        end else if (s_rd) begin
                            re_q    <= 1'b1;
                            state_q <= D_READ;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= A_LO_WAIT;
                        end
                    end
                end
                D_WRITE: begin
                    if (mem_ready_i) begin
                        we_q <= 1'b0;
                        if (w_abort) begin
                            state_q <= A_LO_WAIT;
                        end else begin
                            ack_q   <= 1'b1;
                            state_q <= D_ACK;
                        end
                    end
                end
                D_READ: begin
                    if (mem_ready_i) begin
                        re_q      <= 1'b0;
                        bus_out_q <= mem_rdata_i;
                        if (w_abort) begin
                            state_q <= A_LO_WAIT;
                        end else begin
                            bus_oe_q <= 1'b1;
                            ack_q    <= 1'b1;
                            state_q  <= D_ACK;
                        end
                    end
                end
                D_ACK: begin
                    if (!s_req) begin
                        ack_q    <= 1'b0;
                        bus_oe_q <= 1'b0;
                        state_q  <= A_LO_WAIT;
                    end
                end
                default: begin
                    ack_q    <= 1'b0;
                    bus_oe_q <= 1'b0;
                    state_q  <= A_LO_WAIT;
                end
            endcase
        end
    end

    assign bus_o       = bus_out_q;
    assign bus_oe_o    = bus_oe_q;
    assign ack_o       = ack_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_we_o    = we_q;
    assign mem_re_o    = re_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_target.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mem_bus_target
//  Purpose  : Self-checking bench: CPU handshake driver, latency-programmable
//             memory responder and a byte-array reference memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus_target;

    localparam int SYNC_STAGES = 2;
    localparam int TMO         = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, wr, rd;
    logic [7:0]  bus_in;
    logic [7:0]  bus_out;
    logic        bus_oe, ack, mem_we, mem_re, err, mem_ready;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    mem_bus_target #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .wr_i        (wr),
        .rd_i        (rd),
        .bus_i       (bus_in),
        .bus_o       (bus_out),
        .bus_oe_o    (bus_oe),
        .ack_o       (ack),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_we_o    (mem_we),
        .mem_re_o    (mem_re),
        .mem_rdata_i (mem_rdata),
        .mem_ready_i (mem_ready),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Memory device seen by the DUT, and the bench's own reference image.
    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;
    acc_t acc_q[$];

    int          lat_cfg = 0;
    int          act_cycles = 0;
    int          hold_err = 0;
    int          both_bad = 0;
    bit          rsp_active = 1'b0;
    int          rsp_cnt = 0;
    logic [15:0] rsp_a0 = '0;

    initial begin
        acc_t e;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_we && mem_re) both_bad++;
            if (!(mem_we || mem_re)) begin
                rsp_active = 1'b0;
            end else begin
                if (!rsp_active) begin
                    rsp_active = 1'b1;
                    rsp_cnt    = lat_cfg;
                    rsp_a0     = mem_addr;
                    act_cycles = 0;
                end
                act_cycles++;
                if (mem_addr !== rsp_a0) hold_err++;
                if (rsp_cnt == 0) begin
                    mem_ready = 1'b1;
                    e.we   = mem_we;
                    e.addr = mem_addr;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        e.data = mem_wdata;
                    end else begin
                        mem_rdata = mem[mem_addr];
                        e.data = mem[mem_addr];
                    end
                    acc_q.push_back(e);
                    rsp_active = 1'b0;
                end else begin
                    rsp_cnt--;
                end
            end
        end
    end

    int   ack_rises = 0;
    int   oe_bad = 0;
    logic ack_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (bus_oe && !ack) oe_bad++;
            if (ack && !ack_prev) ack_rises++;
            ack_prev = ack;
        end
    end

    task automatic wait_ack(input logic lvl, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack !== lvl && n < TMO);
        if (ack !== lvl) check_val("ack_timeout", 32'(ack), 32'(lvl));
    endtask

    task automatic send_byte(input logic [7:0] b, output int lat, output logic [7:0] got, output logic got_oe);
        int n;
        bus_in = b;
        req    = 1'b1;
        wait_ack(1'b1, lat);
        got    = bus_out;
        got_oe = bus_oe;
        req    = 1'b0;
        wait_ack(1'b0, n);
    endtask

    task automatic cpu_xfer(input bit is_wr, input bit both, input logic [15:0] a,
                            input logic [7:0] d, input int lat);
        int         l, l2, r0;
        logic [7:0] g;
        logic       oe;
        acc_t       e;
        lat_cfg = lat;
        r0 = ack_rises;
        wr = is_wr;
        rd = !is_wr;
        send_byte(a[7:0], l, g, oe);
        check_val("ack_latency", 32'(l), 32'(SYNC_STAGES + 1));
        send_byte(a[15:8], l2, g, oe);
        if (both) begin
            rd = 1'b1;
            wr = 1'b1;
        end
        send_byte(d, l2, g, oe);
        wr = 1'b0;
        rd = 1'b0;
        check_val("ack_count", 32'(ack_rises - r0), 32'd3);
        check_val("access_count", 32'(acc_q.size()), 32'd1);
        if (acc_q.size() > 0) begin
            e = acc_q.pop_front();
            check_val("access_type", 32'(e.we), 32'(is_wr || both));
            check_val("access_addr", 32'(e.addr), 32'(a));
            if (is_wr || both) begin
                check_val("write_data", 32'(e.data), 32'(d));
                ref_mem[a] = d;
            end
        end
        check_val("strobe_cycles", 32'(act_cycles), 32'(lat + 1));
        if (!(is_wr || both)) begin
            check_val("read_oe", 32'(oe), 32'd1);
            check_val("read_data", 32'(g), 32'(ref_mem[a]));
        end
    endtask

    initial begin
        int          n, l;
        logic [7:0]  g;
        logic        oe;
        bit          w;
        logic [15:0] ra;

        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        rst_n  = 1'b0;
        req    = 1'b0;
        wr     = 1'b0;
        rd     = 1'b0;
        bus_in = '0;
        repeat (3) @(negedge clk);
        check_val("rst_ack", 32'(ack), 32'd0);
        check_val("rst_oe", 32'(bus_oe), 32'd0);
        check_val("rst_bus_out", 32'(bus_out), 32'd0);
        check_val("rst_we_re", 32'({mem_we, mem_re}), 32'd0);
        check_val("rst_addr", 32'(mem_addr), 32'd0);
        check_val("rst_wdata", 32'(mem_wdata), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        cpu_xfer(1'b1, 1'b0, 16'h1234, 8'hA5, 4);
        check_val("wr_err", 32'(err), 32'd0);
        cpu_xfer(1'b0, 1'b0, 16'hBEEF, 8'h00, 0);

        ref_mem[16'h0000] = 8'h3C;
        mem[16'h0000]     = 8'h3C;
        cpu_xfer(1'b0, 1'b0, 16'h0000, 8'h00, 2);
        cpu_xfer(1'b1, 1'b0, 16'hFFFF, 8'h01, 1);
        cpu_xfer(1'b0, 1'b0, 16'hFFFF, 8'h00, 3);

        // Abort after the address-high byte; the stale 0x7777 must not leak.
        lat_cfg = 0;
        rd = 1'b1;
        send_byte(8'h77, l, g, oe);
        send_byte(8'h77, l, g, oe);
        rd = 1'b0;
        repeat (10) @(negedge clk);
        check_val("abort_ack", 32'(ack), 32'd0);
        check_val("abort_no_access", 32'(acc_q.size()), 32'd0);
        cpu_xfer(1'b0, 1'b0, 16'h0102, 8'h00, 1);
        check_val("err_before", 32'(err), 32'd0);

        cpu_xfer(1'b1, 1'b1, 16'h4242, 8'h99, 2);
        check_val("err_set", 32'(err), 32'd1);

        for (int i = 0; i < 24; i++) begin
            w  = bit'($urandom_range(0, 1));
            ra = 16'($urandom);
            cpu_xfer(w, 1'b0, ra, 8'($urandom), int'($urandom_range(0, 6)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        cpu_xfer(1'b0, 1'b0, 16'h4242, 8'h00, 0);
        check_val("err_sticky", 32'(err), 32'd1);

        // Reset while the read is stalled on memory.
        lat_cfg = 40;
        rd = 1'b1;
        send_byte(8'h55, l, g, oe);
        send_byte(8'hAA, l, g, oe);
        bus_in = '0;
        req    = 1'b1;
        n = 0;
        while (mem_re !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("midrd_re_start", 32'(mem_re), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrd_ack", 32'(ack), 32'd0);
        check_val("midrd_oe", 32'(bus_oe), 32'd0);
        check_val("midrd_re", 32'(mem_re), 32'd0);
        check_val("midrd_err", 32'(err), 32'd0);
        req = 1'b0;
        rd  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_val("midrd_no_access", 32'(acc_q.size()), 32'd0);
        cpu_xfer(1'b0, 1'b0, 16'h0102, 8'h00, 2);

        check_val("oe_outside_ack", 32'(oe_bad), 32'd0);
        check_val("addr_hold", 32'(hold_err), 32'd0);
        check_val("we_re_overlap", 32'(both_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
